clock_set_ctrl: RTL
===================

# clock_set_ctrl

Mode controller and time base for the digital clock. Generates the 1 Hz enable for the seconds counter and ripples seconds/minutes carries into minute/hour increment pulses. Runs a RUN / SET_HR / SET_MIN / SET_SEC state machine that lets the user step hours and minutes, or clear seconds, using two debounced keys. Drives per-field blink masks for the display driver.

## Interface
- TICK_DIV, 50_000_000: clk cycles per 1 s tick; even, ≥ 4.
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- key_mode  in  1  debounced level; each rising edge advances mode.
- key_inc  in  1  debounced level; each rising edge is one increment request.
- sec_co  in  1  carry level from seconds counter.
- min_co  in  1  carry level from minutes counter.
- sec_en  out  1  one-cycle enable to seconds counter, RUN only.
- min_inc  out  1  one-cycle increment to minutes counter.
- hr_inc  out  1  one-cycle increment to hours counter.
- sec_clr  out  1  one-cycle clear to seconds counter.
- mode  out  2  0 RUN, 1 SET_HR, 2 SET_MIN, 3 SET_SEC.
- blink_mask  out  3  bit2 hours, bit1 minutes, bit0 seconds; 1 = blank field.

## Operation
- Reset: mode = RUN, prescaler = 0, all pulse outputs 0, blink_mask = 000. Edge-detector history registers load the current input values, so levels already high at reset release produce no edge.
- Prescaler: counts 0..TICK_DIV-1 and wraps, in every mode. Blink phase = 1 when count ≥ TICK_DIV/2.
- Mode FSM: a key_mode rising edge moves RUN→SET_HR→SET_MIN→SET_SEC→RUN. Other inputs do not change the mode.
- RUN:
  - sec_en pulses on prescaler wrap.
  - sec_co rising edge → min_inc.
  - min_co rising edge → hr_inc.
  - key_inc is ignored.
- SET_HR: each key_inc edge → hr_inc.
- SET_MIN: each key_inc edge → min_inc.
- SET_SEC: each key_inc edge → sec_clr.
- In all SET states: sec_en = 0 and carry edges are discarded, not queued.
- SET_SEC→RUN: prescaler forced to 0, so the first second after setting is a full TICK_DIV cycles.
- blink_mask: 000 in RUN. In a SET state, only the selected field's bit is driven, and it equals blink phase.
- Simultaneous events:
  - key_mode edge with key_inc edge: mode advances and the inc edge is dropped.
  - Carry edge in the same cycle RUN→SET_HR: the carry is still forwarded, because the current state was RUN.
  - min_inc from a carry and from a key can never coincide (exclusive states).
- Reset mid-operation: returns to RUN at once. No pulse is emitted in the cycle after reset release.

## Timing
- All outputs are registered.
- An input edge sampled at clock edge k produces its pulse high during cycle k+1, for exactly one cycle.
- sec_en: first assertion TICK_DIV cycles after the first clock edge with reset low, then every TICK_DIV cycles.
- mode and blink_mask update in the cycle after the key_mode edge is sampled.
- Blink period = TICK_DIV cycles, 50 % duty.

## Configuration
- CLOCK_SET_CTRL_AUTOREPEAT_EN defined:
  - In SET_HR or SET_MIN, key_inc held high through a full prescaler wrap after its edge adds one more increment at every subsequent wrap while held.
  - SET_SEC does not repeat.
  - Repeat stops the wrap after release.
- Undefined: exactly one increment per key_inc rising edge, regardless of hold time.

## Structure
- Package clock_set_pkg holds:
  - mode enum typedef (RUN, SET_HR, SET_MIN, SET_SEC);
  - blink_mask bit-index constants (BLK_HR = 2, BLK_MIN = 1, BLK_SEC = 0).
- Sub-module rise_det: one-bit rising-edge detector whose history register loads the input during reset. Instantiated four times (key_mode, key_inc, sec_co, min_co).

## Test plan
All scenarios use TICK_DIV = 8.
- Release reset, idle inputs → sec_en high at cycles 8, 16, 24; mode = 0; blink_mask = 000; no other pulses.
- RUN, raise sec_co at cycle 20 → min_inc high only in cycle 21. Raise min_co at cycle 30 → hr_inc high only in cycle 31.
- Four key_mode presses → mode 1, 2, 3, 0. blink_mask toggles 100/000, then 010/000, then 001/000, with period 8. sec_en absent in modes 1–3.
- SET_MIN, three key_inc presses plus one sec_co edge → exactly three min_inc pulses, no hr_inc, no sec_en. Exit to RUN → next sec_en 8 cycles after the mode change.
- SET_HR, key_mode and key_inc rising in the same cycle → mode = 2, no hr_inc.
- SET_SEC with key_inc and sec_co held high, assert reset 2 cycles, release → mode = 0, no min_inc/sec_clr pulse afterwards, first sec_en 8 cycles later.
- (AUTOREPEAT_EN) SET_HR, hold key_inc 30 cycles → hr_inc at press+1, then at each of the next three wraps.

Source files
------------

// File: rtl/clock_set_pkg.sv
// Shared types and constants for the clock mode controller.
package clock_set_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    SET_SEC = 2'd3
  } mode_e;

  // blink_mask bit positions, 1 = blank that field
  localparam int unsigned BLK_HR  = 2;
  localparam int unsigned BLK_MIN = 1;
  localparam int unsigned BLK_SEC = 0;

endpackage

// File: rtl/rise_det.sv
// One-bit rising-edge detector; history loads the input during reset so
// levels already high at reset release never look like an edge.
module rise_det (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise_c
);

  logic d_q;

  always_ff @(posedge clk) begin
    d_q <= d;
  end

  assign rise_c = d & ~d_q & ~reset;

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode controller and 1 Hz time base for the digital clock.
// Optional build macro CLOCK_SET_CTRL_AUTOREPEAT_EN: held key_inc repeats
// hour/minute increments once per prescaler wrap.
module clock_set_ctrl
  import clock_set_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic       sec_co,
  input  logic       min_co,
  output logic       sec_en,
  output logic       min_inc,
  output logic       hr_inc,
  output logic       sec_clr,
  output logic [1:0] mode,
  output logic [2:0] blink_mask
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(TICK_DIV / 2);

  mode_e            state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sec_en_d, min_inc_d, hr_inc_d, sec_clr_d;
  logic [2:0]       blink_d;
  logic             wrap_c, inc_ok_c, rep_c, phase_d;
  logic             mode_rise_c, inc_rise_c, sec_rise_c, min_rise_c;

  rise_det u_mode_det (.clk(clk), .reset(reset), .d(key_mode), .rise_c(mode_rise_c));
  rise_det u_inc_det  (.clk(clk), .reset(reset), .d(key_inc),  .rise_c(inc_rise_c));
  rise_det u_sec_det  (.clk(clk), .reset(reset), .d(sec_co),   .rise_c(sec_rise_c));
  rise_det u_min_det  (.clk(clk), .reset(reset), .d(min_co),   .rise_c(min_rise_c));

`ifdef CLOCK_SET_CTRL_AUTOREPEAT_EN
  logic rep_arm_q, rep_arm_d, rep_field_c;

  // Armed by an accepted key_inc edge in SET_HR/SET_MIN, dropped on release or mode change
  always_comb begin
    rep_field_c = (state_q == SET_HR) || (state_q == SET_MIN);
    rep_arm_d   = 1'b0;
    if (rep_field_c && !mode_rise_c && key_inc) begin
      rep_arm_d = rep_arm_q | inc_rise_c;
    end
    rep_c = rep_field_c & rep_arm_q & key_inc & wrap_c & ~mode_rise_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rep_arm_q <= 1'b0;
    end else begin
      rep_arm_q <= rep_arm_d;
    end
  end
`else
  assign rep_c = 1'b0;
`endif

  assign wrap_c   = (cnt_q == CNT_MAX);
  assign inc_ok_c = inc_rise_c & ~mode_rise_c;

  always_comb begin
    state_d   = state_q;
    cnt_d     = wrap_c ? '0 : cnt_q + CNT_W'(1);
    sec_en_d  = 1'b0;
    min_inc_d = 1'b0;
    hr_inc_d  = 1'b0;
    sec_clr_d = 1'b0;
    blink_d   = '0;

    if (mode_rise_c) begin
      case (state_q)
        RUN:     state_d = SET_HR;
        SET_HR:  state_d = SET_MIN;
        SET_MIN: state_d = SET_SEC;
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end

    // Pulses depend on the current state, so a carry in the RUN->SET_HR cycle still passes
    case (state_q)
      RUN: begin
        sec_en_d  = wrap_c;
        min_inc_d = sec_rise_c;
        hr_inc_d  = min_rise_c;
      end
      SET_HR:  hr_inc_d  = inc_ok_c | rep_c;
      SET_MIN: min_inc_d = inc_ok_c | rep_c;
      default: sec_clr_d = inc_ok_c;
    endcase

    phase_d = (cnt_d >= CNT_HALF);
    case (state_d)
      SET_HR:  blink_d[BLK_HR]  = phase_d;
      SET_MIN: blink_d[BLK_MIN] = phase_d;
      SET_SEC: blink_d[BLK_SEC] = phase_d;
      default: blink_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      sec_en     <= 1'b0;
      min_inc    <= 1'b0;
      hr_inc     <= 1'b0;
      sec_clr    <= 1'b0;
      blink_mask <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sec_en     <= sec_en_d;
      min_inc    <= min_inc_d;
      hr_inc     <= hr_inc_d;
      sec_clr    <= sec_clr_d;
      blink_mask <= blink_d;
    end
  end

  assign mode = state_q;

endmodule
